// File: rtl/mult_arbiter.sv
// mult_arbiter: four requesters share one 2-stage pipelined signed multiplier.
// A round-robin pointer picks at most one eligible requester per cycle; the
// winner's operands enter the multiplier and its id rides a matching
// valid/id shift register so each product comes back tagged two cycles later.
module mult_arbiter #(
  parameter int WL_A = 16,
  parameter int WL_B = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [3:0]           en_mask,
  input  logic [3:0]           req_valid,
  output logic [3:0]           req_ready,
  input  logic [4*WL_A-1:0]    req_a,
  input  logic [4*WL_B-1:0]    req_b,
  output logic                 res_valid,
  output logic [WL_A+WL_B-1:0] res_data,
  output logic [1:0]           res_id,
  output logic [1:0]           inflight
);

  localparam int WL_P = WL_A + WL_B;

  // arbitration
  logic [1:0] ptr;
  logic [3:0] eligible;
  logic [1:0] scan_idx;
  logic       grant_any;
  logic [1:0] grant_id;

  // multiplier inputs and pipeline
  logic signed [WL_A-1:0] mul_a_in;
  logic signed [WL_B-1:0] mul_b_in;
  logic signed [WL_A-1:0] op_a;
  logic signed [WL_B-1:0] op_b;
  logic signed [WL_P-1:0] ext_a;
  logic signed [WL_P-1:0] ext_b;
  logic signed [WL_P-1:0] prod;
  logic                   v1;
  logic                   v2;
  logic [1:0]             id1;
  logic [1:0]             id2;

  // Round-robin search from ptr; reset forces no grant so req_ready is low
  // while resetn is asserted.
  always_comb begin
    eligible  = req_valid & en_mask & {4{resetn}};
    grant_any = 1'b0;
    grant_id  = ptr;
    scan_idx  = ptr;
    req_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (!grant_any && eligible[scan_idx]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx;
      end
    end
    if (grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Winner's operands feed the multiplier; idle cycles present zeros.
  always_comb begin
    mul_a_in = '0;
    mul_b_in = '0;
    if (grant_any) begin
      mul_a_in = req_a[int'(grant_id)*WL_A +: WL_A];
      mul_b_in = req_b[int'(grant_id)*WL_B +: WL_B];
    end
  end

  // Pointer moves past the winner so it has lowest priority next time.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr <= 2'd0;
    end else if (grant_any) begin
      ptr <= grant_id + 2'd1;
    end
  end

  // Stage 1: capture operands along with the valid/id tag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_a <= '0;
      op_b <= '0;
      v1   <= 1'b0;
      id1  <= 2'd0;
    end else begin
      op_a <= mul_a_in;
      op_b <= mul_b_in;
      v1   <= grant_any;
      id1  <= grant_id;
    end
  end

  // Sign-extend both operands to the full product width so the multiply is
  // exact without relying on context-width rules.
  assign ext_a = {{WL_B{op_a[WL_A-1]}}, op_a};
  assign ext_b = {{WL_A{op_b[WL_B-1]}}, op_b};

  // Stage 2: register the product and advance the tag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prod <= '0;
      v2   <= 1'b0;
      id2  <= 2'd0;
    end else begin
      prod <= ext_a * ext_b;
      v2   <= v1;
      id2  <= id1;
    end
  end

  assign res_valid = v2;
  assign res_data  = prod;
  assign res_id    = id2;
  assign inflight  = {1'b0, v1} + {1'b0, v2};

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: a per-cycle reference model predicts the
// grant and pushes the expected tagged product; a separate monitor pops and
// compares whenever a result is presented.
module tb_mult_arbiter;

  logic        clock;
  logic        resetn;
  logic [3:0]  en_mask;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        res_valid;
  logic [31:0] res_data;
  logic [1:0]  res_id;
  logic [1:0]  inflight;

  mult_arbiter #(.WL_A(16), .WL_B(16)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .en_mask   (en_mask),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .inflight  (inflight)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          stamp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ptr = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int rr_pick(input logic [3:0] elig, input int p);
    for (int k = 0; k < 4; k++) begin
      if (elig[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return x[31:0];
  endfunction

  function automatic logic [63:0] pk(input logic [15:0] x0, input logic [15:0] x1,
                                     input logic [15:0] x2, input logic [15:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  // Reference model: predict this cycle's grant and record the expected result.
  int          g_win;
  logic [3:0]  g_rdy;
  exp_t        g_e;
  always @(negedge clock) begin
    if (!resetn) begin
      n_vec++;
      if (req_ready !== 4'b0 || res_valid !== 1'b0 || inflight !== 2'd0 ||
          res_data !== 32'd0 || res_id !== 2'd0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got rdy=%b rv=%b inf=%0d data=%h id=%0d want all zero",
                 cyc, req_ready, res_valid, inflight, res_data, res_id);
      end
      sb.delete();
      m_ptr = 0;
    end else begin
      g_win = rr_pick(req_valid & en_mask, m_ptr);
      g_rdy = (g_win < 0) ? 4'b0 : 4'(1 << g_win);
      n_vec++;
      if (req_ready !== g_rdy) begin
        n_err++;
        $display("FAIL grant cyc=%0d got %b want %b", cyc, req_ready, g_rdy);
      end
      if (g_win >= 0) begin
        g_e.id    = g_win;
        g_e.data  = mul16(req_a[g_win*16 +: 16], req_b[g_win*16 +: 16]);
        g_e.stamp = cyc;
        sb.push_back(g_e);
        m_ptr = (g_win + 1) % 4;
      end
    end
  end

  // Monitor: occupancy and returned results against the scoreboard.
  int   m_inf;
  exp_t m_e;
  always @(negedge clock) begin
    if (resetn) begin
      m_inf = 0;
      foreach (sb[i]) begin
        if (sb[i].stamp == cyc - 1 || sb[i].stamp == cyc - 2) m_inf++;
      end
      n_vec++;
      if (int'(inflight) != m_inf) begin
        n_err++;
        $display("FAIL inflight cyc=%0d got %0d want %0d", cyc, inflight, m_inf);
      end
      while (sb.size() > 0 && sb[0].stamp < cyc - 2) begin
        m_e = sb.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_result id=%0d accepted=%0d got none want res_valid", m_e.id, m_e.stamp);
      end
      if (res_valid === 1'b1) begin
        n_vec++;
        if (sb.size() > 0 && sb[0].stamp == cyc - 2) begin
          m_e = sb.pop_front();
          if (int'(res_id) != m_e.id) begin
            n_err++;
            $display("FAIL res_id cyc=%0d got %0d want %0d", cyc, res_id, m_e.id);
          end
          n_vec++;
          if (res_data !== m_e.data) begin
            n_err++;
            $display("FAIL res_data cyc=%0d id=%0d got %h want %h", cyc, m_e.id, res_data, m_e.data);
          end
        end else begin
          n_err++;
          $display("FAIL unexpected_result cyc=%0d got id=%0d want no res_valid", cyc, res_id);
        end
      end else if (sb.size() > 0 && sb[0].stamp == cyc - 2) begin
        m_e = sb.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_result cyc=%0d got res_valid=%b want id=%0d", cyc, res_valid, m_e.id);
      end
    end
  end

  task automatic step(input logic rn, input logic [3:0] v, input logic [3:0] en,
                      input logic [63:0] a, input logic [63:0] b);
    @(posedge clock);
    #1;
    resetn    = rn;
    req_valid = v;
    en_mask   = en;
    req_a     = a;
    req_b     = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b0, 4'hF, 64'd0, 64'd0);
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [3:0]  r_v;
  logic [3:0]  r_en;
  logic [3:0]  r_acc;
  logic        r_rn;
  logic [63:0] r_a;
  logic [63:0] r_b;

  initial begin
    resetn    = 1'b0;
    en_mask   = 4'b0;
    req_valid = 4'b0;
    req_a     = 64'd0;
    req_b     = 64'd0;
    repeat (3) step(1'b0, 4'b0, 4'b0, 64'd0, 64'd0);

    // single request from requester 2: 3 * -5
    step(1'b1, 4'b0100, 4'hF, pk(16'd0, 16'd0, 16'd3, 16'd0), pk(16'd0, 16'd0, 16'hFFFB, 16'd0));
    idle(4);

    // fresh pointer, then all four held valid
    repeat (2) step(1'b0, 4'b0, 4'hF, 64'd0, 64'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'hF, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});

    // masked requesters 0 and 2
    for (int i = 0; i < 4; i++) step(1'b1, 4'hF, 4'b1010, {$urandom, $urandom}, {$urandom, $urandom});
    idle(2);

    // extreme operands
    step(1'b1, 4'b0001, 4'hF, pk(16'h8000, 16'd0, 16'd0, 16'd0), pk(16'h8000, 16'd0, 16'd0, 16'd0));
    step(1'b1, 4'b0001, 4'hF, pk(16'h7FFF, 16'd0, 16'd0, 16'd0), pk(16'h8000, 16'd0, 16'd0, 16'd0));
    idle(3);

    // two products in flight, then reset; next grant from pointer 0
    step(1'b1, 4'b0001, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    step(1'b1, 4'b0010, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    step(1'b0, 4'b0, 4'hF, 64'd0, 64'd0);
    step(1'b0, 4'b0, 4'hF, 64'd0, 64'd0);
    step(1'b1, 4'b1010, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    idle(3);

    // requester 1 withdraws while requester 3 stays valid
    step(1'b1, 4'b0100, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    step(1'b1, 4'b1010, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    step(1'b1, 4'b1000, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    idle(3);

    // randomized traffic: requesters hold until accepted, may withdraw
    r_v  = 4'b0;
    r_en = 4'hF;
    r_a  = 64'd0;
    r_b  = 64'd0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      r_acc = req_ready & req_valid;
      for (int i = 0; i < 4; i++) begin
        if (r_acc[i] || !r_v[i]) begin
          r_v[i] = ($urandom_range(0, 9) < 6);
          r_a[i*16 +: 16] = rnd_op();
          r_b[i*16 +: 16] = rnd_op();
        end else if ($urandom_range(0, 19) == 0) begin
          r_v[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 9) == 0) r_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      r_rn = ($urandom_range(0, 499) != 0);
      step(r_rn, r_v, r_en, r_a, r_b);
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
